// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite write/read-back self-test master for bring-up of slave register files.
// Walks C_NUM_REGS registers, checks RESP and read data, reports pass/fail and first failure.
module axi_lite_selftest_master #(
   parameter int          C_ADDR_WIDTH  = 32,
   parameter int          C_DATA_WIDTH  = 32,
   parameter int          C_NUM_REGS    = 4,
   parameter int          C_ADDR_STRIDE = 4,
   parameter longint      C_BASE_ADDR   = 0,
   parameter int          C_MODE        = 0,
   parameter int          C_TIMEOUT     = 255,
   parameter logic [31:0] C_PAT_INC     = 32'h9E3779B9
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      start,
   input  logic [C_DATA_WIDTH-1:0]   seed,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [7:0]                err_count,
   output logic [7:0]                fail_index,
   output logic [C_DATA_WIDTH-1:0]   fail_data,
   output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                M_AXI_AWPROT,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                M_AXI_ARPROT,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
   localparam logic [TW-1:0]           T_LAST   = TW'(C_TIMEOUT - 1);
   localparam logic [C_DATA_WIDTH-1:0] PAT      = {(C_DATA_WIDTH/32){C_PAT_INC}};
   localparam logic [C_ADDR_WIDTH-1:0] BASE     = C_ADDR_WIDTH'(C_BASE_ADDR);
   localparam logic [C_ADDR_WIDTH-1:0] STRIDE   = C_ADDR_WIDTH'(C_ADDR_STRIDE);
   localparam logic [7:0]              LAST_IDX = 8'(C_NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WA, S_WB, S_RA, S_RD, S_ADV, S_DONE
   } state_t;

   state_t                  state, state_n;
   logic                    aw_ok, w_ok;
   logic [TW-1:0]           tcnt;
   logic [7:0]              idx;
   logic [C_ADDR_WIDTH-1:0] addr_q;
   logic [C_DATA_WIDTH-1:0] data_q, seed_q;
   logic                    wr_phase, fail_seen;

   logic start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, expire, last;
   logic b_err, r_rerr, r_derr;
   logic [1:0] err_add;
   logic [8:0] err_sum;

   always_ff @(posedge ACLK) begin
      if (ARESET) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      start_ok      = 1'b0;
      aw_hs         = 1'b0;
      w_hs          = 1'b0;
      b_hs          = 1'b0;
      ar_hs         = 1'b0;
      r_hs          = 1'b0;
      expire        = 1'b0;
      last          = (idx == LAST_IDX);
      case (state)
         S_IDLE, S_DONE: begin
            start_ok = start;
            if (start) state_n = S_WA;
         end
         S_WA: begin
            // AW and W channels complete independently; leave only once both have.
            M_AXI_AWVALID = !aw_ok;
            M_AXI_WVALID  = !w_ok;
            aw_hs = !aw_ok && M_AXI_AWREADY;
            w_hs  = !w_ok && M_AXI_WREADY;
            if ((aw_ok || aw_hs) && (w_ok || w_hs)) state_n = S_WB;
            else expire = (tcnt == T_LAST);
         end
         S_WB: begin
            M_AXI_BREADY = 1'b1;
            b_hs = M_AXI_BVALID;
            if (b_hs) state_n = (C_MODE == 0) ? S_RA : S_ADV;
            else      expire  = (tcnt == T_LAST);
         end
         S_RA: begin
            M_AXI_ARVALID = 1'b1;
            ar_hs = M_AXI_ARREADY;
            if (ar_hs) state_n = S_RD;
            else       expire  = (tcnt == T_LAST);
         end
         S_RD: begin
            M_AXI_RREADY = 1'b1;
            r_hs = M_AXI_RVALID;
            if (r_hs) state_n = S_ADV;
            else      expire  = (tcnt == T_LAST);
         end
         S_ADV: begin
            if (wr_phase)  state_n = last ? S_RA : S_WA;
            else if (last) state_n = S_DONE;
            else           state_n = (C_MODE == 0) ? S_WA : S_RA;
         end
         default: state_n = S_IDLE;
      endcase
      if (expire) state_n = S_DONE;
   end

   assign busy         = (state == S_WA) || (state == S_WB) || (state == S_RA) ||
                         (state == S_RD) || (state == S_ADV);
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = data_q;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   // A single read can contribute both a RESP error and a data mismatch.
   assign b_err   = b_hs && (M_AXI_BRESP != 2'b00);
   assign r_rerr  = r_hs && (M_AXI_RRESP != 2'b00);
   assign r_derr  = r_hs && (M_AXI_RDATA != data_q);
   assign err_add = {1'b0, b_err} + {1'b0, r_rerr} + {1'b0, r_derr};
   assign err_sum = {1'b0, err_count} + {7'd0, err_add};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tcnt       <= '0;
         aw_ok      <= 1'b0;
         w_ok       <= 1'b0;
         idx        <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         seed_q     <= '0;
         wr_phase   <= 1'b0;
         fail_seen  <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
         err_count  <= '0;
         fail_index <= '0;
         fail_data  <= '0;
      end else begin
         if (state_n != state)  tcnt <= '0;
         else if (tcnt != T_LAST) tcnt <= tcnt + 1'b1;

         if (state != S_WA) begin
            aw_ok <= 1'b0;
            w_ok  <= 1'b0;
         end else begin
            if (aw_hs) aw_ok <= 1'b1;
            if (w_hs)  w_ok  <= 1'b1;
         end

         if (start_ok) begin
            seed_q     <= seed;
            data_q     <= seed;
            addr_q     <= BASE;
            idx        <= '0;
            wr_phase   <= (C_MODE != 0);
            fail_seen  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            fail_data  <= '0;
         end

         if (err_add != 2'd0) begin
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if (!fail_seen) begin
               fail_seen  <= 1'b1;
               fail_index <= idx;
               fail_data  <= r_hs ? M_AXI_RDATA : '0;
            end
         end

         // Pattern and address advance by accumulation; write-all mode rewinds for the read pass.
         if (state == S_ADV) begin
            if (wr_phase && last) begin
               idx      <= '0;
               addr_q   <= BASE;
               data_q   <= seed_q;
               wr_phase <= 1'b0;
            end else if (!last) begin
               idx    <= idx + 1'b1;
               addr_q <= addr_q + STRIDE;
               data_q <= data_q + PAT;
            end else begin
               done <= 1'b1;
               pass <= (err_count == 8'd0);
            end
         end

         if (expire) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Bench for axi_lite_selftest_master: one behavioural AXI4-Lite RAM slave muxed between
// a write+read-per-reg instance (short timeout) and a write-all-then-read-all instance.
`timescale 1ns/1ps
module tb_axi_lite_selftest_master;

   localparam logic [31:0] INC = 32'h9E3779B9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst, start, busy, done, pass, tmo;
   logic [31:0] seed [2], fail_data [2], awaddr [2], wdata [2], araddr [2];
   logic [7:0]  err [2], fidx [2];
   logic [2:0]  awprot [2], arprot [2];
   logic [3:0]  wstrb [2];
   logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  arvalid, arready, rvalid, rready;

   logic        sel;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, srst;
   logic [1:0]  s_bresp, s_rresp;

   int cfg_wlag;
   bit cfg_rrand, cfg_arblock, cfg_mask2, cfg_berr1, mon_en, log_clr;
   int n_tests, n_fail;

   axi_lite_selftest_master #(.C_MODE(0), .C_TIMEOUT(15)) u_m0 (
      .ACLK(clk), .ARESET(rst[0]), .start(start[0]), .seed(seed[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
      .err_count(err[0]), .fail_index(fidx[0]), .fail_data(fail_data[0]),
      .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWPROT(awprot[0]), .M_AXI_AWVALID(awvalid[0]),
      .M_AXI_AWREADY(awready[0]), .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]),
      .M_AXI_WVALID(wvalid[0]), .M_AXI_WREADY(wready[0]), .M_AXI_BRESP(s_bresp),
      .M_AXI_BVALID(bvalid[0]), .M_AXI_BREADY(bready[0]), .M_AXI_ARADDR(araddr[0]),
      .M_AXI_ARPROT(arprot[0]), .M_AXI_ARVALID(arvalid[0]), .M_AXI_ARREADY(arready[0]),
      .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(rvalid[0]),
      .M_AXI_RREADY(rready[0]));

   axi_lite_selftest_master #(.C_MODE(1)) u_m1 (
      .ACLK(clk), .ARESET(rst[1]), .start(start[1]), .seed(seed[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
      .err_count(err[1]), .fail_index(fidx[1]), .fail_data(fail_data[1]),
      .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWPROT(awprot[1]), .M_AXI_AWVALID(awvalid[1]),
      .M_AXI_AWREADY(awready[1]), .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]),
      .M_AXI_WVALID(wvalid[1]), .M_AXI_WREADY(wready[1]), .M_AXI_BRESP(s_bresp),
      .M_AXI_BVALID(bvalid[1]), .M_AXI_BREADY(bready[1]), .M_AXI_ARADDR(araddr[1]),
      .M_AXI_ARPROT(arprot[1]), .M_AXI_ARVALID(arvalid[1]), .M_AXI_ARREADY(arready[1]),
      .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(rvalid[1]),
      .M_AXI_RREADY(rready[1]));

   // Slave is connected to whichever master sel picks; the other sees no handshakes.
   assign s_awaddr  = awaddr[sel];
   assign s_awvalid = awvalid[sel];
   assign s_wdata   = wdata[sel];
   assign s_wvalid  = wvalid[sel];
   assign s_bready  = bready[sel];
   assign s_araddr  = araddr[sel];
   assign s_arvalid = arvalid[sel];
   assign s_rready  = rready[sel];
   assign srst      = rst[sel];
   assign awready   = {sel & s_awready, ~sel & s_awready};
   assign wready    = {sel & s_wready,  ~sel & s_wready};
   assign bvalid    = {sel & s_bvalid,  ~sel & s_bvalid};
   assign arready   = {sel & s_arready, ~sel & s_arready};
   assign rvalid    = {sel & s_rvalid,  ~sel & s_rvalid};

   logic [31:0] mem [16];
   logic [31:0] a_q, d_q, wl_addr [16], wl_data [16];
   logic        aw_got, w_got, bv, rv, rpend, ar_seen;
   logic [1:0]  br;
   logic [3:0]  ra_q;
   int          wcnt = 0, rdly = 0, wn = 0, wn_at_ar = 0;
   logic        aw_fire, w_fire, ar_fire, commit;
   logic [31:0] c_addr, c_data, c_wdat;
   logic [3:0]  c_idx;

   assign s_awready = !aw_got && !bv;
   assign s_wready  = !w_got && !bv && (wcnt >= cfg_wlag);
   assign s_arready = !cfg_arblock && !rpend && !rv;
   assign aw_fire   = s_awvalid && s_awready;
   assign w_fire    = s_wvalid && s_wready;
   assign ar_fire   = s_arvalid && s_arready;
   assign commit    = (aw_got || aw_fire) && (w_got || w_fire);
   assign c_addr    = aw_got ? a_q : s_awaddr;
   assign c_data    = w_got ? d_q : s_wdata;
   assign c_idx     = c_addr[5:2];
   assign c_wdat    = (cfg_mask2 && c_idx == 4'd2) ? (c_data & 32'hFFFF0000) : c_data;
   assign s_bvalid  = bv;
   assign s_bresp   = br;
   assign s_rvalid  = rv;
   assign s_rresp   = 2'b00;

   always @(posedge clk) begin
      if (srst) begin
         aw_got <= 1'b0; w_got <= 1'b0; wcnt <= 0; bv <= 1'b0; br <= 2'b00;
         rpend <= 1'b0; rdly <= 0; rv <= 1'b0; s_rdata <= '0;
      end else begin
         if (aw_fire) begin aw_got <= 1'b1; a_q <= s_awaddr; end
         if (w_fire) begin w_got <= 1'b1; d_q <= s_wdata; wcnt <= 0; end
         else if (s_wvalid && !w_got) wcnt <= wcnt + 1;
         if (commit) begin
            mem[c_idx] <= c_wdat;
            bv <= 1'b1;
            br <= (cfg_berr1 && c_idx == 4'd1) ? 2'b10 : 2'b00;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            wl_addr[wn[3:0]] <= c_addr;
            wl_data[wn[3:0]] <= c_data;
            wn <= wn + 1;
         end
         if (bv && s_bready) bv <= 1'b0;
         if (ar_fire) begin
            rpend <= 1'b1;
            ra_q  <= s_araddr[5:2];
            rdly  <= cfg_rrand ? int'($urandom_range(7, 0)) : 0;
            if (!ar_seen) begin ar_seen <= 1'b1; wn_at_ar <= wn; end
         end
         if (rpend && !rv) begin
            if (rdly == 0) begin rv <= 1'b1; s_rdata <= mem[ra_q]; rpend <= 1'b0; end
            else rdly <= rdly - 1;
         end
         if (rv && s_rready) rv <= 1'b0;
      end
      if (log_clr) begin wn <= 0; ar_seen <= 1'b0; wn_at_ar <= 0; end
   end

   // VALID must hold with stable payload until READY.
   logic        pv_aw, pv_w, pv_ar;
   logic [31:0] pa_aw, pd_w, pa_ar;
   int          viol = 0;
   always @(posedge clk) begin
      if (srst) begin
         pv_aw <= 1'b0; pv_w <= 1'b0; pv_ar <= 1'b0;
      end else begin
         pv_aw <= s_awvalid && !s_awready; pa_aw <= s_awaddr;
         pv_w  <= s_wvalid && !s_wready;   pd_w  <= s_wdata;
         pv_ar <= s_arvalid && !s_arready; pa_ar <= s_araddr;
         if (mon_en && ((pv_aw && (!s_awvalid || s_awaddr != pa_aw)) ||
                        (pv_w  && (!s_wvalid  || s_wdata  != pd_w))  ||
                        (pv_ar && (!s_arvalid || s_araddr != pa_ar))))
            viol <= viol + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] s, input int i);
      return s + INC * 32'(i);
   endfunction

   task automatic pulse_start(input int k, input logic [31:0] s);
      @(negedge clk);
      seed[k]  = s;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input string tag);
      for (int c = 0; c < 400 && !done[k]; c++) @(negedge clk);
      chk({tag, "_done"}, done[k], 1);
   endtask

   task automatic clear_log();
      @(negedge clk);
      log_clr = 1'b1;
      @(negedge clk);
      log_clr = 1'b0;
   endtask

   logic [31:0] t1_exp [4] = '{32'h0101FFFF, 32'h9F3979B8, 32'h3D70F371, 32'hDBA86D2A};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int arcnt;
      bit found;
      n_tests = 0; n_fail = 0;
      rst = 2'b11; start = 2'b00; sel = 1'b0;
      seed[0] = '0; seed[1] = '0;
      cfg_wlag = 0; cfg_rrand = 0; cfg_arblock = 0; cfg_mask2 = 0; cfg_berr1 = 0;
      mon_en = 0; log_clr = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy0", busy[0], 0);
      chk("rst_done0", done[0], 0);
      chk("rst_err0",  err[0], 0);
      chk("rst_awv0",  awvalid[0], 0);
      chk("rst_busy1", busy[1], 0);
      chk("rst_arv1",  arvalid[1], 0);
      rst = 2'b00;
      mon_en = 1;

      // T1: zero-wait slave, write+read per register
      clear_log();
      pulse_start(0, 32'h0101FFFF);
      chk("t1_busy", busy[0], 1);
      wait_done(0, "t1");
      chk("t1_pass", pass[0], 1);
      chk("t1_err",  err[0], 0);
      chk("t1_tmo",  tmo[0], 0);
      chk("t1_fidx", fidx[0], 0);
      chk("t1_fdat", fail_data[0], 0);
      chk("t1_wn",   wn, 4);
      chk("t1_order", wn_at_ar, 1);
      chk("t1_strb_prot", {wstrb[0], awprot[0], arprot[0]}, 10'h3C0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_addr%0d", i), wl_addr[i], 32'(i * 4));
         chk($sformatf("t1_data%0d", i), wl_data[i], t1_exp[i]);
      end
      chk("t1_busy_end", busy[0], 0);

      // T2: WREADY lags AWREADY by 3 cycles, random read latency
      cfg_wlag = 3; cfg_rrand = 1;
      clear_log();
      pulse_start(0, 32'h0101FFFF);
      wait_done(0, "t2");
      chk("t2_pass", pass[0], 1);
      chk("t2_err",  err[0], 0);
      chk("t2_wn",   wn, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t2_data%0d", i), wl_data[i], pat(32'h0101FFFF, i));
      chk("t2_hold", viol, 0);

      // T3: slave corrupts register 2
      cfg_wlag = 0; cfg_rrand = 0; cfg_mask2 = 1;
      pulse_start(0, 32'h0101FFFF);
      wait_done(0, "t3");
      chk("t3_err",  err[0], 1);
      chk("t3_fidx", fidx[0], 2);
      chk("t3_fdat", fail_data[0], 32'h3D700000);
      chk("t3_pass", pass[0], 0);
      chk("t3_tmo",  tmo[0], 0);

      // T4: SLVERR write response on register 1
      cfg_mask2 = 0; cfg_berr1 = 1;
      pulse_start(0, 32'h0101FFFF);
      wait_done(0, "t4");
      chk("t4_err",  err[0], 1);
      chk("t4_fidx", fidx[0], 1);
      chk("t4_fdat", fail_data[0], 0);
      chk("t4_pass", pass[0], 0);

      // T5: AR never accepted
      cfg_berr1 = 0; cfg_arblock = 1; mon_en = 0;
      pulse_start(0, 32'h00000001);
      arcnt = 0;
      for (int c = 0; c < 400 && !done[0]; c++) begin
         @(negedge clk);
         if (arvalid[0]) arcnt++;
      end
      chk("t5_done",  done[0], 1);
      chk("t5_arcnt", arcnt, 15);
      chk("t5_tmo",   tmo[0], 1);
      chk("t5_pass",  pass[0], 0);
      chk("t5_arv",   arvalid[0], 0);
      chk("t5_busy",  busy[0], 0);
      cfg_arblock = 0;
      repeat (2) @(negedge clk);
      mon_en = 1;

      // T6: write-all/read-all master, reset during register 2 write
      sel = 1'b1;
      clear_log();
      pulse_start(1, 32'hCAFE0001);
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (awvalid[1] && awaddr[1] == 32'h8) found = 1;
      end
      chk("t6_reach_reg2", found, 1);
      rst[1] = 1'b1;
      @(negedge clk);
      chk("t6_rst_busy", busy[1], 0);
      chk("t6_rst_awv",  awvalid[1], 0);
      chk("t6_rst_wv",   wvalid[1], 0);
      chk("t6_rst_addr", awaddr[1], 0);
      chk("t6_rst_wdat", wdata[1], 0);
      chk("t6_rst_done", done[1], 0);
      rst[1] = 1'b0;
      clear_log();
      pulse_start(1, 32'h13579BDF);
      repeat (6) @(negedge clk);
      chk("t6_busy", busy[1], 1);
      pulse_start(1, 32'hFFFFFFFF);
      wait_done(1, "t6");
      chk("t6_pass",  pass[1], 1);
      chk("t6_err",   err[1], 0);
      chk("t6_tmo",   tmo[1], 0);
      chk("t6_wn",    wn, 4);
      chk("t6_order", wn_at_ar, 4);
      chk("t6_data0", wl_data[0], 32'h13579BDF);
      chk("t6_data3", wl_data[3], pat(32'h13579BDF, 3));
      chk("t6_addr3", wl_addr[3], 32'hC);
      chk("t6_strb",  {wstrb[1], awprot[1], arprot[1]}, 10'h3C0);
      chk("t6_hold",  viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
